// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings for branch redirect control: PC-source select values and FSM states.
// The IF-stage PC mux decodes the same PC_SEL_* values.
package branch_redirect_ctrl_pkg;

    localparam logic [1:0] PC_SEL_SEQ     = 2'd0;
    localparam logic [1:0] PC_SEL_PRED    = 2'd1;
    localparam logic [1:0] PC_SEL_RECOVER = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter used for branch performance statistics.
module branch_redirect_ctrl_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch prediction sequencing and misprediction recovery for the 5-stage core.
// Holds the not-chosen PC of the in-flight branch and steers the PC mux / pipeline flush.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             id_branch_i,
    input  logic [PC_W-1:0]  id_pc_i,
    input  logic [PC_W-1:0]  id_imm_i,
    input  logic             predict_i,
    input  logic             ex_branch_i,
    input  logic             ex_taken_i,
    output logic [1:0]       pc_sel_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             mispredict_o,
    output logic             err_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    state_t            state_reg;
    logic              pred_reg;
    logic [PC_W-1:0]   rec_pc_reg;
    logic              err_reg;

    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   fallthru;
    logic              resolve;
    logic              capture;

    assign target   = id_pc_i + {id_imm_i[PC_W-2:0], 1'b0};
    assign fallthru = id_pc_i + PC_W'(4);

    // Gating with rst keeps every combinational output at 0 while reset is held.
    always_comb begin
        resolve       = rst && ex_branch_i && (state_reg == ST_PEND);
        mispredict_o  = resolve && (pred_reg ^ ex_taken_i);
        capture       = rst && id_branch_i && !stall_i && (state_reg != ST_RECOVER) && !mispredict_o;
        pc_sel_o      = PC_SEL_SEQ;
        redirect_pc_o = '0;
        flush_o       = 1'b0;
        if (mispredict_o) begin
            pc_sel_o      = PC_SEL_RECOVER;
            redirect_pc_o = rec_pc_reg;
            flush_o       = 1'b1;
        end else if (capture && predict_i) begin
            pc_sel_o      = PC_SEL_PRED;
            redirect_pc_o = target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            pred_reg   <= 1'b0;
            rec_pc_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (ex_branch_i && (state_reg != ST_PEND)) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (capture) state_reg <= ST_PEND;
                end
                ST_PEND: begin
                    if (mispredict_o)            state_reg <= ST_RECOVER;
                    else if (resolve && !capture) state_reg <= ST_IDLE;
                end
                // One bubble cycle while the flushed slot drains through ID.
                ST_RECOVER: begin
                    if (!stall_i) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
            if (capture) begin
                pred_reg   <= predict_i;
                rec_pc_reg <= predict_i ? fallthru : target;
            end
        end
    end

    assign err_o = err_reg;

    branch_redirect_ctrl_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve),
        .count (branch_cnt_o)
    );

    branch_redirect_ctrl_sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict_o),
        .count (mispred_cnt_o)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed scoreboard bench for branch_redirect_ctrl: vectors push expected responses,
// a negedge monitor pops and compares each cycle.
module tb_branch_redirect_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall_i;
    logic             id_branch_i;
    logic [PC_W-1:0]  id_pc_i;
    logic [PC_W-1:0]  id_imm_i;
    logic             predict_i;
    logic             ex_branch_i;
    logic             ex_taken_i;
    logic [1:0]       pc_sel_o;
    logic [PC_W-1:0]  redirect_pc_o;
    logic             flush_o;
    logic             mispredict_o;
    logic             err_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    typedef struct {
        string           name;
        logic [1:0]      sel;
        logic [PC_W-1:0] pc;
        logic            flush;
        logic            misp;
        logic            err;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .id_branch_i   (id_branch_i),
        .id_pc_i       (id_pc_i),
        .id_imm_i      (id_imm_i),
        .predict_i     (predict_i),
        .ex_branch_i   (ex_branch_i),
        .ex_taken_i    (ex_taken_i),
        .pc_sel_o      (pc_sel_o),
        .redirect_pc_o (redirect_pc_o),
        .flush_o       (flush_o),
        .mispredict_o  (mispredict_o),
        .err_o         (err_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    task automatic check(input string tname, input string field,
                         input logic [PC_W-1:0] act, input logic [PC_W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h required %0h", tname, field, act, req);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue its expected response.
    task automatic step(input string name, input logic r, input logic s,
                        input logic ib, input logic [PC_W-1:0] ipc, input logic [PC_W-1:0] imm,
                        input logic pr, input logic eb, input logic et,
                        input logic [1:0] esel, input logic [PC_W-1:0] epc,
                        input logic ef, input logic em, input logic ee,
                        input logic [CNT_W-1:0] ebc, input logic [CNT_W-1:0] emc);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        stall_i     = s;
        id_branch_i = ib;
        id_pc_i     = ipc;
        id_imm_i    = imm;
        predict_i   = pr;
        ex_branch_i = eb;
        ex_taken_i  = et;
        e.name = name; e.sel = esel; e.pc = epc; e.flush = ef; e.misp = em;
        e.err = ee; e.bc = ebc; e.mc = emc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn %-10s sel=%0d pc=%08h flush=%0b misp=%0b err=%0b bc=%0d mc=%0d",
                     e.name, pc_sel_o, redirect_pc_o, flush_o, mispredict_o, err_o,
                     branch_cnt_o, mispred_cnt_o);
            check(e.name, "pc_sel",   PC_W'(pc_sel_o),      PC_W'(e.sel));
            check(e.name, "redirect", redirect_pc_o,        e.pc);
            check(e.name, "flush",    PC_W'(flush_o),       PC_W'(e.flush));
            check(e.name, "misp",     PC_W'(mispredict_o),  PC_W'(e.misp));
            check(e.name, "err",      PC_W'(err_o),         PC_W'(e.err));
            check(e.name, "bcnt",     PC_W'(branch_cnt_o),  PC_W'(e.bc));
            check(e.name, "mcnt",     PC_W'(mispred_cnt_o), PC_W'(e.mc));
        end
    end

    initial begin
        rst = 1'b0; stall_i = 1'b0; id_branch_i = 1'b0; id_pc_i = '0; id_imm_i = '0;
        predict_i = 1'b0; ex_branch_i = 1'b0; ex_taken_i = 1'b0;
        repeat (2) @(posedge clk);

        //   name         rst stl idb pc           imm          pr eb et | sel pc           fl mp er bc mc
        step("reset",      0, 0, 0, 32'h0,      32'h0,        0, 0, 0,   0, 32'h0,        0, 0, 0, 0, 0);
        // taken, predicted correctly
        step("t2_id",      1, 0, 1, 32'h100,    32'h10,       1, 0, 0,   1, 32'h120,      0, 0, 0, 0, 0);
        step("t2_ex",      1, 0, 0, 32'h0,      32'h0,        0, 1, 1,   0, 32'h0,        0, 0, 0, 0, 0);
        // predicted taken, actually not taken; next ID branch ignored in recovery
        step("t3_id",      1, 0, 1, 32'h100,    32'h10,       1, 0, 0,   1, 32'h120,      0, 0, 0, 1, 0);
        step("t3_ex",      1, 0, 0, 32'h0,      32'h0,        0, 1, 0,   2, 32'h104,      1, 1, 0, 1, 0);
        step("t3_recov",   1, 0, 1, 32'h300,    32'h4,        1, 0, 0,   0, 32'h0,        0, 0, 0, 2, 1);
        // predicted not taken with negative offset, actually taken
        step("t4_id",      1, 0, 1, 32'h200,    32'hFFFFFFF8, 0, 0, 0,   0, 32'h0,        0, 0, 0, 2, 1);
        step("t4_ex",      1, 0, 0, 32'h0,      32'h0,        0, 1, 1,   2, 32'h1F0,      1, 1, 0, 2, 1);
        step("t4_recov",   1, 0, 0, 32'h0,      32'h0,        0, 0, 0,   0, 32'h0,        0, 0, 0, 3, 2);
        // mispredict collides with a younger ID branch, which is squashed
        step("t5a_id",     1, 0, 1, 32'h400,    32'h8,        1, 0, 0,   1, 32'h410,      0, 0, 0, 3, 2);
        step("t5a_coll",   1, 0, 1, 32'h500,    32'h8,        1, 1, 0,   2, 32'h404,      1, 1, 0, 3, 2);
        step("t5a_recov",  1, 0, 0, 32'h0,      32'h0,        0, 0, 0,   0, 32'h0,        0, 0, 0, 4, 3);
        // correct resolve with a new ID branch: registers reload, stays pending
        step("t5b_id",     1, 0, 1, 32'h600,    32'h20,       0, 0, 0,   0, 32'h0,        0, 0, 0, 4, 3);
        step("t5b_coll",   1, 0, 1, 32'h700,    32'h10,       1, 1, 0,   1, 32'h720,      0, 0, 0, 4, 3);
        step("t5b_ex",     1, 0, 0, 32'h0,      32'h0,        0, 1, 0,   2, 32'h704,      1, 1, 0, 5, 3);
        step("t5b_recov",  1, 0, 0, 32'h0,      32'h0,        0, 0, 0,   0, 32'h0,        0, 0, 0, 6, 4);
        // stall blocks capture; stray EX resolve in IDLE raises sticky error
        step("stall_id",   1, 1, 1, 32'h800,    32'h4,        1, 0, 0,   0, 32'h0,        0, 0, 0, 6, 4);
        step("err_ex",     1, 0, 0, 32'h0,      32'h0,        0, 1, 1,   0, 32'h0,        0, 0, 0, 6, 4);
        step("err_seen",   1, 0, 0, 32'h0,      32'h0,        0, 0, 0,   0, 32'h0,        0, 0, 1, 6, 4);
        // back-to-back correct resolves drive branch count into saturation
        step("sat_id",     1, 0, 1, 32'h100,    32'h10,       1, 0, 0,   1, 32'h120,      0, 0, 1, 6, 4);
        for (int k = 0; k < 12; k++) begin
            logic [CNT_W-1:0] ebc;
            ebc = (6 + k > 15) ? 4'd15 : CNT_W'(6 + k);
            step("sat_run",  1, 0, 1, 32'h100,    32'h10,       1, 1, 1,   1, 32'h120,      0, 0, 1, ebc, 4);
        end
        step("sat_misp",   1, 0, 0, 32'h0,      32'h0,        0, 1, 0,   2, 32'h104,      1, 1, 1, 15, 4);
        step("sat_hold",   1, 0, 0, 32'h0,      32'h0,        0, 0, 0,   0, 32'h0,        0, 0, 1, 15, 5);
        // asynchronous reset while a branch is pending
        step("t1_id",      1, 0, 1, 32'h100,    32'h10,       1, 0, 0,   1, 32'h120,      0, 0, 1, 15, 5);
        step("t1_rst",     0, 0, 1, 32'h100,    32'h10,       1, 1, 0,   0, 32'h0,        0, 0, 0, 0, 0);
        step("t1_after",   1, 0, 0, 32'h0,      32'h0,        0, 0, 0,   0, 32'h0,        0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
